// File: rtl/keypad_scanner_if.sv
// Pin- and display-side signals of the 4x4 keypad scanner.
// master = scanner, slave = keypad pins / display logic.
interface keypad_scanner_if;
  logic [3:0] column;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [4:0] ld;

  modport master (input column, output row, key_code, key_valid, key_held, ld);
  modport slave  (output column, input row, key_code, key_valid, key_held, ld);
endinterface

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad controller with frame-level debounce.
// Reports accepted presses as row*4+col with a strobe and a held flag.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, DEB, PRESSED, REL} state_t;

  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic          hit_vld;
  logic [3:0]    hit_code;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    cand, cand_n;
  logic [3:0]    key_code, key_code_n;
  logic          key_valid, key_held, key_held_n, enter_press;

  logic          dwell_end, frame_end, row_hit, frame_key;
  logic [1:0]    col_idx;
  logic [3:0]    row_code, frame_code;

  assign dwell_end = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (row_idx == 2'd3);
  assign row_hit   = ~&col_s2;

  // Lowest-index pressed column wins within a row.
  always_comb begin
    col_idx = 2'd0;
    for (int c = 3; c >= 0; c--)
      if (!col_s2[c]) col_idx = 2'(c);
  end

  assign row_code   = {row_idx, col_idx};
  assign frame_key  = hit_vld | row_hit;
  assign frame_code = hit_vld ? hit_code : row_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1   <= 4'hF;
      col_s2   <= 4'hF;
      div_cnt  <= '0;
      row_idx  <= 2'd0;
      hit_vld  <= 1'b0;
      hit_code <= 4'd0;
    end else begin
      col_s1 <= kp.column;
      col_s2 <= col_s1;
      if (dwell_end) begin
        div_cnt <= '0;
        row_idx <= row_idx + 2'd1;
        // Earlier rows keep priority; the frame result is consumed at row 3.
        if (row_idx == 2'd3)
          hit_vld <= 1'b0;
        else if (row_hit && !hit_vld) begin
          hit_vld  <= 1'b1;
          hit_code <= row_code;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // State register (outputs are registered alongside the state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_code  <= key_code_n;
      key_valid <= enter_press;
      key_held  <= key_held_n;
    end
  end

  assign cnt_inc = (cnt == CW'(DEBOUNCE)) ? cnt : cnt + CW'(1);

  // Next-state logic, evaluated only at the row-3 sample.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    if (frame_end) begin
      case (state)
        IDLE: if (frame_key) begin
          cand_n  = frame_code;
          cnt_n   = CW'(1);
          state_n = (DEBOUNCE == 1) ? PRESSED : DEB;
        end
        DEB: if (!frame_key) begin
          state_n = IDLE;
        end else if (frame_code == cand) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE)) state_n = PRESSED;
        end else begin
          cand_n = frame_code;
          cnt_n  = CW'(1);
        end
        PRESSED: if (!frame_key) begin
          cnt_n   = CW'(1);
          state_n = (DEBOUNCE == 1) ? IDLE : REL;
        end
        REL: if (frame_key) begin
          state_n = PRESSED;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output logic: strobe only on entry to PRESSED from the pre-acceptance states.
  always_comb begin
    enter_press = (state == IDLE || state == DEB) && (state_n == PRESSED);
    key_held_n  = (state_n == PRESSED) || (state_n == REL);
    key_code_n  = enter_press ? cand_n : key_code;
  end

  assign kp.row       = ~(4'b0001 << row_idx);
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;
  assign kp.ld        = {key_held, key_code};
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized self-checking bench for keypad_scanner against a frame-level
// press/release model driven by a behavioural 4x4 keypad.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = 16'h0;
  int          checks = 0, failures = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif.master)
  );

  always #5 clk = ~clk;

  // Keypad: a held key shorts its row to its column.
  always_comb begin
    kif.column = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.row[r] && keys[r*4+c]) kif.column[c] = 1'b0;
  end

  // Reference model state
  int         k;            // edges since reset release
  int         last_code, code_run, none_run;
  bit         held, exp_vld;
  logic [3:0] exp_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t k=%0d)", tag, got, exp, $time, k);
    end
  endtask

  task automatic model_reset();
    k = 0; last_code = -1; code_run = 0; none_run = 0;
    held = 0; exp_vld = 0; exp_code = 4'd0;
  endtask

  // Frame value: the lowest set key index, since index = row*4+col.
  task automatic model_frame(input logic [15:0] ks);
    int v;
    v = -1;
    for (int i = 15; i >= 0; i--) if (ks[i]) v = i;
    if (v < 0) begin
      last_code = -1; code_run = 0;
      if (held) begin
        none_run++;
        if (none_run >= DB) held = 0;
      end
    end else begin
      none_run = 0;
      if (v == last_code) code_run++;
      else begin last_code = v; code_run = 1; end
      if (!held && code_run >= DB) begin
        held = 1; exp_code = 4'(v); exp_vld = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] rexp;
    rexp = ~(4'b0001 << ((k / SD) % 4));
    chk("row", kif.row, rexp);
    chk("key_valid", kif.key_valid, exp_vld);
    chk("key_held", kif.key_held, held);
    chk("key_code", kif.key_code, exp_code);
    chk("ld", kif.ld, {held, exp_code});
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      exp_vld = 0;
      if (k % FRAME == 0) model_frame(keys);
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic frames(input logic [15:0] ks, input int n);
    keys = ks;
    run_cycles(n * FRAME);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rk;
    model_reset();
    do_reset(2);
    // Row stepping with no keys
    frames(16'h0, 1);
    // Stable press of row2/col1 (code 9), then release
    frames(16'h0200, 5);
    frames(16'h0, 3);
    // Re-accept, then a single pressed frame inside the release window
    frames(16'h0200, 3);
    frames(16'h0, 1);
    frames(16'h0200, 1);
    frames(16'h0, 3);
    // Bounce on row0/col2 never accepted
    frames(16'h0004, 2);
    frames(16'h0, 1);
    frames(16'h0004, 2);
    frames(16'h0, 3);
    // Priority across rows, then within a row
    frames(16'h0018, 3);
    frames(16'h0, 3);
    frames(16'h0500, 3);
    frames(16'h0, 3);
    // Reset mid-debounce
    frames(16'h8000, 2);
    run_cycles(5);
    keys = 16'h0;
    do_reset(1);
    frames(16'h0, 2);
    // Randomized bursts
    rk = 16'h0;
    for (int b = 0; b < 60; b++) begin
      case ($urandom_range(0, 3))
        0: rk = 16'h0;
        1: rk = 16'h1 << $urandom_range(0, 15);
        2: rk = 16'($urandom);
        default: ;
      endcase
      frames(rk, $urandom_range(1, 4));
      if ($urandom_range(0, 15) == 0) begin
        run_cycles($urandom_range(1, FRAME - 1));
        do_reset(1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning controller for the 4x4 matrix keypad. It drives the four row lines one at a time (active-low), samples the pulled-up column lines, and debounces across full scan frames. It reports each accepted key press as a 4-bit code with a one-cycle strobe and a held-level flag. It sits between the keypad pins and the LED/display logic, replacing the static all-rows-low column test with full per-key decoding.

## Interface

- SCAN_DIV, 50000, clock cycles each row is driven before advancing; minimum 4.
- DEBOUNCE, 4, consecutive identical frames required to accept a press or a release; minimum 1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- column  in  4  keypad column lines, active-low, externally pulled up; asynchronous to clk.
- row  out  4  row drive, active-low one-hot; exactly one bit low at all times.
- key_code  out  4  code of the last accepted key, row_idx*4 + col_idx.
- key_valid  out  1  one-cycle strobe when a press is accepted.
- key_held  out  1  high while the accepted key is considered pressed.
- ld  out  5  LED drive: ld[3:0] = key_code, ld[4] = key_held.

## Operation

- column passes through a 2-flop synchronizer before use.
- Row sequencer:
  - row_idx 0..3 drives row = ~(1<<row_idx).
  - A dwell counter runs 0..SCAN_DIV-1. At count SCAN_DIV-1, the synchronized column is sampled, row_idx increments (3 wraps to 0) and the counter clears.
- Per-row decode: if any sampled column bit is 0, col_idx is the lowest-index zero bit. A hit records {row_idx, col_idx} only if no earlier row in the same frame already hit.
- Frame: rows 0..3. The frame result (key code or "none") is evaluated at the row-3 sample, then the frame hit register clears.
- Debounce FSM, updated only at frame end; cnt saturates at DEBOUNCE:
  - IDLE:
    - key frame → cand = code, cnt = 1; go to PRESSED if DEBOUNCE==1, else DEBOUNCE.
    - none → stay.
  - DEBOUNCE:
    - same code → cnt++; on reaching DEBOUNCE go to PRESSED.
    - different code → cand = new code, cnt = 1.
    - none → IDLE.
  - Entry to PRESSED: key_code <= cand, key_valid = 1 for one cycle, key_held = 1.
  - PRESSED:
    - any key frame (same or different code) → stay; no new strobe.
    - none → cnt = 1, go to RELEASE (or straight to IDLE if DEBOUNCE==1).
  - RELEASE:
    - none → cnt++; on reaching DEBOUNCE go to IDLE and clear key_held.
    - any key frame → back to PRESSED; no new strobe.
- key_code holds its value after release until the next accepted press.

## Timing

- Reset values: row = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, ld = 5'b00000, FSM = IDLE, all counters and candidate cleared, synchronizer flops = 4'b1111.
- Row timing: row is 1110 for SCAN_DIV cycles after reset release, then 1101, 1011, 0111, then wraps.
- Sampling: column is sampled at the end of each dwell, so the 2-cycle synchronizer delay settles inside the dwell.
- Output latency: key_valid, key_held, key_code and ld all update on the clock edge after the frame-end sample, at the same edge.
- Press latency: with the key stable from before a frame start, acceptance comes at the end of frame DEBOUNCE.
- Release latency: DEBOUNCE full "none" frames.
- rst asserted at any cycle, including mid-dwell or mid-debounce, forces reset values on the next edge. No strobe is issued for an interrupted press.
- Simultaneous keys:
  - different rows → lowest row_idx wins;
  - same row → lowest col_idx wins.

## Test plan

Bench parameters: SCAN_DIV=4, DEBOUNCE=3.

1. Reset: hold rst 2 cycles, columns 1111 → row=1110 and all outputs 0. Then row steps 1110→1101→1011→0111→1110, each held 4 cycles.
2. Stable press: column[1]=0 whenever row==1011, held for 5 frames → exactly one key_valid pulse at end of frame 3; key_code=9, ld=5'b11001, key_held stays 1; no further pulses.
3. Bounce: row0/col2 press for 2 frames, then 1 frame none, then 2 frames pressed → no key_valid; key_held stays 0.
4. Release: after scenario 2, columns 1111 → key_held drops at end of 3rd none frame; ld=5'b01001, key_code stays 9. A single pressed frame inside the release window → key_held stays 1, no strobe.
5. Priority: row0/col3 and row1/col0 pressed together → key_code=3. Row2 with columns 0 and 2 both low → key_code=8.
6. Reset mid-debounce: press row3/col3 for 2 frames, pulse rst for 1 cycle → key_valid never asserts, key_code=0, row=1110 on the next edge.
